// File: rtl/rvvi_serializer_pkg.sv
// ---------------------------------------------------------------------------
// rvvi_serializer_pkg
//   Shared types and constants for the RVVI retire serializer.
//   - retire_rec_t : one trace record at the default XLEN, MSB first:
//                    {order, insn, pc, trap, mode, rd_wen, rd_addr, rd_wdata}
//   - REC_W        : record width at the default XLEN
//   - rec_width()  : record width for any XLEN (used by parameterised RTL)
//   - MODE_*       : RISC-V privilege mode encodings
// ---------------------------------------------------------------------------
package rvvi_serializer_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] MODE_U = 2'd0;
    localparam logic [1:0] MODE_S = 2'd1;
    localparam logic [1:0] MODE_M = 2'd3;

    typedef struct packed {
        logic [63:0]         order;
        logic [31:0]         insn;
        logic [XLEN_DEF-1:0] pc;
        logic                trap;
        logic [1:0]          mode;
        logic                rd_wen;
        logic [4:0]          rd_addr;
        logic [XLEN_DEF-1:0] rd_wdata;
    } retire_rec_t;

    localparam int REC_W = $bits(retire_rec_t);

    function automatic int rec_width(input int xlen);
        return 64 + 32 + xlen + 1 + 2 + 1 + 5 + xlen;
    endfunction

endpackage

// File: rtl/rvvi_slot_compact.sv
// ---------------------------------------------------------------------------
// rvvi_slot_compact
//   Combinational compaction of NRET retire slots into a contiguous array of
//   trace records. Valid slots keep ascending slot order; gaps in in_valid
//   are squeezed out so record k is the k-th valid slot.
//   Ports:
//     in_*        per-slot RVVI fields, slot i at bits [i*W +: W]
//     rec_packed  NRET records of rec_width(XLEN) bits, record k at [k*RW +: RW]
//                 (unused tail records are zero)
//     n           number of valid slots (popcount of in_valid)
// ---------------------------------------------------------------------------
module rvvi_slot_compact
    import rvvi_serializer_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NRET = 2,
    localparam int RW   = rec_width(XLEN),
    localparam int CW   = $clog2(NRET + 1)
) (
    input  logic [NRET-1:0]      in_valid,
    input  logic [NRET*64-1:0]   in_order,
    input  logic [NRET*32-1:0]   in_insn,
    input  logic [NRET*XLEN-1:0] in_pc,
    input  logic [NRET-1:0]      in_trap,
    input  logic [NRET*2-1:0]    in_mode,
    input  logic [NRET-1:0]      in_rd_wen,
    input  logic [NRET*5-1:0]    in_rd_addr,
    input  logic [NRET*XLEN-1:0] in_rd_wdata,
    output logic [NRET*RW-1:0]   rec_packed,
    output logic [CW-1:0]        n
);

    // NOTE: blocking assignments here on purpose -- n is a running prefix
    // count, so each slot must see the value updated by the slots below it.
    always_comb begin
        rec_packed = '0;
        n          = '0;
        for (int i = 0; i < NRET; i++) begin
            if (in_valid[i]) begin
                rec_packed[int'(n)*RW +: RW] = {in_order[i*64 +: 64],
                                                in_insn[i*32 +: 32],
                                                in_pc[i*XLEN +: XLEN],
                                                in_trap[i],
                                                in_mode[i*2 +: 2],
                                                in_rd_wen[i],
                                                in_rd_addr[i*5 +: 5],
                                                in_rd_wdata[i*XLEN +: XLEN]};
                n = n + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvvi_retire_serializer.sv
// ---------------------------------------------------------------------------
// rvvi_retire_serializer
//   Serialises up to NRET RVVI retirements per cycle into a single in-order
//   record stream for the ISA coverage sampler, via a circular FIFO.
//   A retire group either fits entirely (counting a same-cycle pop) or is
//   dropped as a whole; drops set a sticky flag and a saturating counter.
//   Output is show-ahead and registered: out_rec is the head record.
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     in_*                  per-slot retire inputs (see rvvi_slot_compact)
//     out_valid/out_ready   head-record handshake
//     out_rec               {order, insn, pc, trap, mode, rd_wen, rd_addr, rd_wdata}
//     level                 FIFO occupancy (0..DEPTH)
//     overflow, drop_count  sticky drop flag, saturating dropped-record count
//     order_err             sticky order-gap flag
//   Optional: define RVVI_ORDER_CHECK_EN to enable the order checker;
//   without it order_err is tied 0.
// ---------------------------------------------------------------------------
module rvvi_retire_serializer
    import rvvi_serializer_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NRET  = 2,
    parameter  int DEPTH = 16,
    parameter  int CNTW  = 16,
    localparam int RW    = rec_width(XLEN),
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRET-1:0]      in_valid,
    input  logic [NRET*64-1:0]   in_order,
    input  logic [NRET*32-1:0]   in_insn,
    input  logic [NRET*XLEN-1:0] in_pc,
    input  logic [NRET-1:0]      in_trap,
    input  logic [NRET*2-1:0]    in_mode,
    input  logic [NRET-1:0]      in_rd_wen,
    input  logic [NRET*5-1:0]    in_rd_addr,
    input  logic [NRET*XLEN-1:0] in_rd_wdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RW-1:0]        out_rec,
    output logic [LW-1:0]        level,
    output logic                 overflow,
    output logic [CNTW-1:0]      drop_count,
    output logic                 order_err
);

    localparam int CW = $clog2(NRET + 1);

    logic [NRET*RW-1:0] rec_packed;
    logic [CW-1:0]      n;

    rvvi_slot_compact #(
        .XLEN (XLEN),
        .NRET (NRET)
    ) u_compact (
        .in_valid    (in_valid),
        .in_order    (in_order),
        .in_insn     (in_insn),
        .in_pc       (in_pc),
        .in_trap     (in_trap),
        .in_mode     (in_mode),
        .in_rd_wen   (in_rd_wen),
        .in_rd_addr  (in_rd_addr),
        .in_rd_wdata (in_rd_wdata),
        .rec_packed  (rec_packed),
        .n           (n)
    );

    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
    logic [LW-1:0] level_next;
    logic [LW:0]   free;
    logic          pop, push, drop;
    logic [CNTW:0] drop_sum;

    assign pop         = out_valid & out_ready;
    // A same-cycle pop frees its entry for this cycle's push.
    assign free        = (LW+1)'(DEPTH) - {1'b0, level} + (LW+1)'(pop);
    assign drop        = (LW+1)'(n) > free;
    assign push        = (n != '0) && !drop;
    assign rd_ptr_next = rd_ptr + AW'(pop);
    assign drop_sum    = {1'b0, drop_count} + (CNTW+1)'(n);

    always_comb begin
        level_next = level;
        if (push) level_next = level_next + LW'(n);
        level_next = level_next - LW'(pop);
    end

    // NOTE: the storage array has no reset; the pointers and level alone
    // define which entries are meaningful, so clearing data buys nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int k = 0; k < NRET; k++) begin
                if (k < int'(n)) mem[wr_ptr + AW'(k)] <= rec_packed[k*RW +: RW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            out_valid  <= 1'b0;
            out_rec    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(n);
            rd_ptr    <= rd_ptr_next;
            level     <= level_next;
            out_valid <= (level_next != '0);
            // When nothing older survives this cycle, the new head is the
            // first record being pushed now and is not in mem yet. Otherwise
            // the head entry is occupied, so this cycle's write cannot hit it.
            if (level == LW'(pop)) out_rec <= rec_packed[RW-1:0];
            else                   out_rec <= mem[rd_ptr_next];
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[CNTW] ? '1 : drop_sum[CNTW-1:0];
            end
        end
    end

`ifdef RVVI_ORDER_CHECK_EN
    logic        exp_valid;
    logic [63:0] exp_order;
    logic        order_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_valid   <= 1'b0;
            exp_order   <= '0;
            order_err_q <= 1'b0;
        end else begin
            if (pop) begin
                if (exp_valid && (out_rec[RW-1 -: 64] != exp_order)) order_err_q <= 1'b1;
                exp_order <= out_rec[RW-1 -: 64] + 64'd1;
                exp_valid <= 1'b1;
            end
            // A dropped group leaves a legitimate gap: re-seed on the next pop.
            if (drop) exp_valid <= 1'b0;
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvvi_retire_serializer.sv
module tb_rvvi_retire_serializer;

    localparam int XLEN = 32;
    localparam int NRET = 2;
    localparam int DEPTH = 16;
    localparam int CNTW = 16;
    localparam int RW = 64 + 32 + XLEN + 1 + 2 + 1 + 5 + XLEN;  // 169

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NRET-1:0]      in_valid;
    logic [NRET*64-1:0]   in_order;
    logic [NRET*32-1:0]   in_insn;
    logic [NRET*XLEN-1:0] in_pc;
    logic [NRET-1:0]      in_trap;
    logic [NRET*2-1:0]    in_mode;
    logic [NRET-1:0]      in_rd_wen;
    logic [NRET*5-1:0]    in_rd_addr;
    logic [NRET*XLEN-1:0] in_rd_wdata;
    logic                 out_valid;
    logic                 out_ready;
    logic [RW-1:0]        out_rec;
    logic [5:0]           level;
    logic                 overflow;
    logic [CNTW-1:0]      drop_count;
    logic                 order_err;

    rvvi_retire_serializer #(
        .XLEN (XLEN), .NRET (NRET), .DEPTH (DEPTH), .CNTW (CNTW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_order    (in_order),
        .in_insn     (in_insn),
        .in_pc       (in_pc),
        .in_trap     (in_trap),
        .in_mode     (in_mode),
        .in_rd_wen   (in_rd_wen),
        .in_rd_addr  (in_rd_addr),
        .in_rd_wdata (in_rd_wdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rec     (out_rec),
        .level       (level),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .order_err   (order_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus state ----------------
    logic [RW-1:0] slot_rec [NRET];
    logic [NRET-1:0] vld;
    logic [63:0] next_order;

    // ---------------- reference model ----------------
    logic [RW-1:0] q [$];
    int            m_drop;
    bit            m_ovf;
    bit            m_exp_v;
    logic [63:0]   m_exp;
    bit            m_oerr;

    function automatic logic [RW-1:0] make_rec(input logic [63:0] ord, input logic [31:0] pc);
        logic [1:0] md;
        case ($urandom_range(0, 2))
            0:       md = 2'd0;
            1:       md = 2'd1;
            default: md = 2'd3;
        endcase
        return {ord, 32'($urandom), pc, 1'($urandom), md, 1'($urandom),
                5'($urandom), 32'($urandom)};
    endfunction

    // Fill both slots (invalid ones get junk); valid slots get consecutive orders.
    task automatic set_slots(input logic [NRET-1:0] v);
        vld = v;
        for (int i = 0; i < NRET; i++) begin
            if (v[i]) begin
                slot_rec[i] = make_rec(next_order, 32'($urandom));
                next_order++;
            end else begin
                slot_rec[i] = make_rec(64'hdead_0000 + 64'($urandom_range(0, 255)), 32'($urandom));
            end
        end
        drive();
    endtask

    task automatic drive();
        in_valid = vld;
        for (int i = 0; i < NRET; i++) begin
            in_order[i*64 +: 64]      = slot_rec[i][168:105];
            in_insn[i*32 +: 32]       = slot_rec[i][104:73];
            in_pc[i*XLEN +: XLEN]     = slot_rec[i][72:41];
            in_trap[i]                = slot_rec[i][40];
            in_mode[i*2 +: 2]         = slot_rec[i][39:38];
            in_rd_wen[i]              = slot_rec[i][37];
            in_rd_addr[i*5 +: 5]      = slot_rec[i][36:32];
            in_rd_wdata[i*XLEN +: XLEN] = slot_rec[i][31:0];
        end
    endtask

    // Compare the DUT against the model, then advance both by one clock.
    task automatic cycle();
        int n;
        int free;
        bit pop;
        logic [RW-1:0] head;
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) check("out_rec", out_rec, q[0]);
        check("level", level, q.size());
        check("overflow", overflow, m_ovf);
        check("drop_count", drop_count, m_drop);
        check("order_err", order_err, m_oerr);

        pop = (q.size() != 0) && out_ready;
        n = 0;
        for (int i = 0; i < NRET; i++) if (vld[i]) n++;
        free = DEPTH - q.size() + (pop ? 1 : 0);
        if (pop) begin
            head = q.pop_front();
`ifdef RVVI_ORDER_CHECK_EN
            if (m_exp_v && head[168:105] != m_exp) m_oerr = 1;
`endif
            m_exp   = head[168:105] + 64'd1;
            m_exp_v = 1;
        end
        if (n <= free) begin
            for (int i = 0; i < NRET; i++) if (vld[i]) q.push_back(slot_rec[i]);
        end else begin
            m_ovf  = 1;
            m_drop = m_drop + n;
            if (m_drop > 65535) m_drop = 65535;
            m_exp_v = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        set_slots('0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_drop = 0; m_ovf = 0; m_exp_v = 0; m_exp = '0; m_oerr = 0;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] bp_expect;
    int          bp_pushed, bp_popped;

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        next_order = 0;
        do_reset();

        // Reset state
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_rec", out_rec, '0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_drop_count", drop_count, 0);
        check("rst_order_err", order_err, 1'b0);

        // Single retire into an empty FIFO, sampler ready
        out_ready = 1'b1;
        vld = 2'b01;
        slot_rec[0] = make_rec(64'd5, 32'h8000_0000);
        slot_rec[1] = make_rec(64'd99, 32'h0);
        drive();
        cycle();
        set_slots('0);
        check("single_valid", out_valid, 1'b1);
        check("single_order", out_rec[168:105], 64'd5);
        check("single_pc", out_rec[72:41], 32'h8000_0000);
        cycle();
        check("single_drained", level, 0);

        // Slot 1 only: gap squeezed out
        out_ready = 1'b0;
        vld = 2'b10;
        slot_rec[0] = make_rec(64'd1234, 32'h0);
        slot_rec[1] = make_rec(64'd7, 32'h8000_0004);
        drive();
        cycle();
        set_slots('0);
        check("slot1_level", level, 1);
        check("slot1_order", out_rec[168:105], 64'd7);
        out_ready = 1'b1;
        repeat (2) cycle();

        // Burst to full, then a dropped group
        out_ready = 1'b0;
        next_order = 100;
        repeat (8) begin
            set_slots(2'b11);
            cycle();
        end
        check("burst_full_level", level, 16);
        check("burst_no_overflow", overflow, 1'b0);
        set_slots(2'b11);
        cycle();
        check("drop_overflow", overflow, 1'b1);
        check("drop_count_2", drop_count, 2);
        check("drop_level", level, 16);
        check("drop_head", out_rec[168:105], 64'd100);

        // Full FIFO, pop and 1-slot push in the same cycle
        out_ready = 1'b1;
        set_slots(2'b01);
        cycle();
        check("full_push_pop_level", level, 16);
        check("full_push_pop_drops", drop_count, 2);
        set_slots('0);
        repeat (18) cycle();

        // Backpressure: ready toggles; stream stays in order
        do_reset();
        next_order = 0;
        bp_expect = 0; bp_pushed = 0; bp_popped = 0;
        for (int i = 0; i < 40; i++) begin
            out_ready = (i < 20) ? ((i % 2) == 0) : 1'b1;
            if (i < 20) begin
                case ($urandom_range(0, 2))
                    0: set_slots(2'b01);
                    1: set_slots(2'b10);
                    default: set_slots(2'b00);
                endcase
            end else begin
                set_slots('0);
            end
            for (int s = 0; s < NRET; s++) if (vld[s]) bp_pushed++;
            if (out_valid && out_ready) begin
                check("bp_order", out_rec[168:105], bp_expect);
                bp_expect++;
                bp_popped++;
            end
            cycle();
        end
        check("bp_count", bp_popped, bp_pushed);

        // Reset asserted mid-burst clears contents immediately
        out_ready = 1'b0;
        repeat (3) begin
            set_slots(2'b11);
            cycle();
        end
        #2 reset = 1'b1;
        #1;
        check("midrst_level", level, 0);
        check("midrst_out_valid", out_valid, 1'b0);
        do_reset();

        // Randomized traffic with bursty backpressure
        for (int i = 0; i < 600; i++) begin
            if ((i / 50) % 2 == 0) out_ready = ($urandom_range(0, 3) == 0);
            else                   out_ready = ($urandom_range(0, 3) != 0);
            set_slots(2'($urandom));
            cycle();
        end
        out_ready = 1'b1;
        set_slots('0);
        repeat (20) cycle();

`ifdef RVVI_ORDER_CHECK_EN
        // Order gap 10, 11, 13 flagged on the third pop
        do_reset();
        next_order = 10;
        set_slots(2'b11);
        cycle();
        next_order = 13;
        set_slots(2'b01);
        cycle();
        set_slots('0);
        out_ready = 1'b1;
        cycle();
        cycle();
        check("oc_no_err_yet", order_err, 1'b0);
        cycle();
        check("oc_gap_err", order_err, 1'b1);
        repeat (2) cycle();

        // Drop then resume at 50, tracked by the model
        do_reset();
        next_order = 20;
        repeat (9) begin
            set_slots(2'b11);
            cycle();
        end
        out_ready = 1'b1;
        set_slots('0);
        repeat (17) cycle();
        next_order = 50;
        set_slots(2'b11);
        cycle();
        set_slots('0);
        repeat (4) cycle();
`endif

        // Drop counter saturation
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8 + 32770; i++) begin
            set_slots(2'b11);
            cycle();
        end
        check("drop_saturated", drop_count, 16'hffff);
        check("sat_level", level, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rvvi_retire_serializer.md
Name: rvvi_retire_serializer

Overview:
- Sits directly upstream of the RISC-V ISA coverage collector.
- Captures per-cycle RVVI retirement events from up to NRET retire slots per hart cycle.
- Compacts them into a single in-order stream of trace records, buffered in a circular FIFO.
- Hands records one per cycle to the coverage sampler over a valid/ready handshake, decoupling multi-issue retirement bursts from the single-record sampler.

Parameters:
- XLEN, 32, register/PC width in bits.
- NRET, 2, number of retire slots sampled per cycle (1..4).
- DEPTH, 16, FIFO entries; power of two, >= NRET.
- CNTW, 16, width of saturating drop counter.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  NRET  per-slot retire valid.
- in_order  in  NRET*64  per-slot RVVI order number.
- in_insn  in  NRET*32  per-slot instruction word.
- in_pc  in  NRET*XLEN  per-slot PC.
- in_trap  in  NRET  per-slot trap flag.
- in_mode  in  NRET*2  per-slot privilege mode.
- in_rd_wen  in  NRET  per-slot GPR write enable.
- in_rd_addr  in  NRET*5  per-slot destination register.
- in_rd_wdata  in  NRET*XLEN  per-slot writeback data.
- out_valid  out  1  head record available.
- out_ready  in  1  sampler accepts head record.
- out_rec  out  64+32+XLEN+1+2+1+5+XLEN  head record {order, insn, pc, trap, mode, rd_wen, rd_addr, rd_wdata}.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a retire group was dropped.
- drop_count  out  CNTW  saturating count of dropped records.
- order_err  out  1  sticky order-check failure (only with macro; tied 0 otherwise).

Behaviour:
- Reset (async assert, sync release): wr_ptr, rd_ptr, level = 0; out_valid = 0; out_rec = 0; overflow = 0; drop_count = 0; order_err = 0; expected-order register invalid.
- Per cycle: n = popcount(in_valid). Valid slots are written in ascending slot index, packed contiguously from wr_ptr; gaps in in_valid are squeezed out.
- Pop: occurs when out_valid && out_ready.
- Free space for this cycle = DEPTH - level + pop. A same-cycle pop frees its entry for a push.
- Push: if n <= free, all n records are written and wr_ptr += n mod DEPTH.
- Drop: if n > free, the whole group is dropped (no partial write); overflow <= 1; drop_count += n, saturating at all-ones.
- level_next = level + pushed - pop.
- Output is show-ahead: out_valid = (level != 0) and out_rec = mem[rd_ptr], registered. Latency from in_valid to out_valid is 1 cycle when empty.
- out_rec holds stable while out_valid && !out_ready.
- Pointers wrap modulo DEPTH. Full means level == DEPTH; empty means level == 0.
- n = 0: no write, counters unchanged.
- Reset asserted mid-burst discards all contents immediately; sticky flags clear only on reset.

Optional Feature:
- Macro RVVI_ORDER_CHECK_EN.
- With it defined: on each pop, if the expected-order register is valid and out_rec.order != expected, set order_err. Then expected <= out_rec.order + 1, and the register becomes valid. After any drop, the register is invalidated so the next pop only re-seeds it.
- Without it: no order logic; order_err driven 0.

Decomposition:
- Package rvvi_serializer_pkg holds:
  - retire_rec_t packed struct, parameterised by XLEN via localparam defaults.
  - REC_W constant.
  - Mode encoding constants (U = 0, S = 1, M = 3).
- Sub-module rvvi_slot_compact: combinational prefix-popcount compaction of NRET slots into packed records plus count n. This is the natural split; the FIFO and flag logic stay in the top level.

Test Plan:
- Single retire, empty FIFO, out_ready = 1: slot0 valid with order = 5, pc = 0x80000000 -> out_valid next cycle with order 5; level returns to 0 the cycle after.
- NRET = 2 with in_valid = 2'b10 (slot1 only, order = 7) -> exactly one record with order 7; level = 1.
- Burst: both slots valid for 8 cycles, out_ready = 0, DEPTH = 16 -> level = 16 with no drop. A 9th burst -> overflow = 1, drop_count = 2, level stays 16, contents unchanged.
- Full FIFO with out_ready = 1 and a 1-slot push in the same cycle -> push accepted, level stays 16, no overflow.
- Backpressure: out_ready toggled 1/0 for 20 cycles -> out_rec stable while stalled; records emerge in strictly ascending order 0..N-1.
- RVVI_ORDER_CHECK_EN: inject orders 10, 11, 13 -> order_err set on the third pop. Drop then resume at order 50 -> no order_err.
